// File: rtl/estacionamiento_pkg.sv
// rtl/estacionamiento_pkg.sv - lane-state encoding, sensor patterns and counting helper
package estacionamiento_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENT1 = 3'd1,
    ST_ENT2 = 3'd2,
    ST_ENT3 = 3'd3,
    ST_SAL1 = 3'd4,
    ST_SAL2 = 3'd5,
    ST_SAL3 = 3'd6
  } estado_carril_t;

  // Sensor patterns are written {a,b}
  localparam logic [1:0] PAT_00 = 2'b00;
  localparam logic [1:0] PAT_01 = 2'b01;
  localparam logic [1:0] PAT_10 = 2'b10;
  localparam logic [1:0] PAT_11 = 2'b11;

  function automatic logic [3:0] cuenta_bits(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/fsm_carril.sv
// rtl/fsm_carril.sv - one lane: entry/exit transit FSM with registered one-cycle pulses
module fsm_carril
  import estacionamiento_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic A,
  input  logic B,
  output logic INGRESO,
  output logic EGRESO
);

  estado_carril_t estado, estado_sig;
  logic [1:0]     pat;
  logic           ingreso_sig, egreso_sig;

  assign pat = {A, B};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado  <= ST_IDLE;
      INGRESO <= 1'b0;
      EGRESO  <= 1'b0;
    end else begin
      estado  <= estado_sig;
      INGRESO <= ingreso_sig;
      EGRESO  <= egreso_sig;
    end
  end

  // Exit states mirror the entry states with a and b swapped
  always_comb begin
    estado_sig = ST_IDLE;
    case (estado)
      ST_IDLE: begin
        if (pat == PAT_10)      estado_sig = ST_ENT1;
        else if (pat == PAT_01) estado_sig = ST_SAL1;
      end
      ST_ENT1: begin
        if (pat == PAT_10)      estado_sig = ST_ENT1;
        else if (pat == PAT_11) estado_sig = ST_ENT2;
      end
      ST_ENT2: begin
        if (pat == PAT_11)      estado_sig = ST_ENT2;
        else if (pat == PAT_01) estado_sig = ST_ENT3;
        else if (pat == PAT_10) estado_sig = ST_ENT1;
      end
      ST_ENT3: begin
        if (pat == PAT_01)      estado_sig = ST_ENT3;
        else if (pat == PAT_11) estado_sig = ST_ENT2;
      end
      ST_SAL1: begin
        if (pat == PAT_01)      estado_sig = ST_SAL1;
        else if (pat == PAT_11) estado_sig = ST_SAL2;
      end
      ST_SAL2: begin
        if (pat == PAT_11)      estado_sig = ST_SAL2;
        else if (pat == PAT_10) estado_sig = ST_SAL3;
        else if (pat == PAT_01) estado_sig = ST_SAL1;
      end
      ST_SAL3: begin
        if (pat == PAT_10)      estado_sig = ST_SAL3;
        else if (pat == PAT_11) estado_sig = ST_SAL2;
      end
      default: estado_sig = ST_IDLE;
    endcase
  end

  always_comb begin
    ingreso_sig = (estado == ST_ENT3) && (pat == PAT_00);
    egreso_sig  = (estado == ST_SAL3) && (pat == PAT_00);
  end

endmodule

// File: rtl/control_estacionamiento_n.sv
// rtl/control_estacionamiento_n.sv - multi-lane parking occupancy counter with full-lot blink
module control_estacionamiento_n
  import estacionamiento_pkg::*;
#(
  parameter int N_CARRILES    = 2,
  parameter int CAPACIDAD     = 7,
  parameter int MEDIO_PERIODO = 24000000,
  localparam int CNT_W        = $clog2(CAPACIDAD + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N_CARRILES-1:0] SENS_A,
  input  logic [N_CARRILES-1:0] SENS_B,
  output logic [CNT_W-1:0]      OCUPACION,
  output logic                  LLENO,
  output logic                  VACIO,
  output logic                  LED_LLENO,
  output logic                  RECHAZO,
  output logic                  ERR_EGRESO
);

  localparam int BLINK_W = (MEDIO_PERIODO > 1) ? $clog2(MEDIO_PERIODO) : 1;

  logic [N_CARRILES-1:0] sa_m, sa_s, sb_m, sb_s;
  logic [N_CARRILES-1:0] ingreso, egreso;
  logic [3:0]            n_i, n_e;
  logic [8:0]            i9, e9, ocup9, cap9, acc_e, acc_i, tras, libre;
  logic [CNT_W-1:0]      ocup_sig;
  logic                  rech_sig, err_sig;
  logic [BLINK_W-1:0]    cnt_blink;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sa_m <= '0;
      sa_s <= '0;
      sb_m <= '0;
      sb_s <= '0;
    end else begin
      sa_m <= SENS_A;
      sa_s <= sa_m;
      sb_m <= SENS_B;
      sb_s <= sb_m;
    end
  end

  for (genvar g = 0; g < N_CARRILES; g++) begin : g_carril
    fsm_carril u_carril (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .A      (sa_s[g]),
      .B      (sb_s[g]),
      .INGRESO(ingreso[g]),
      .EGRESO (egreso[g])
    );
  end

  // Exits free space before entries claim it; both saturate instead of wrapping
  always_comb begin
    n_i      = cuenta_bits(8'(ingreso));
    n_e      = cuenta_bits(8'(egreso));
    i9       = {5'b0, n_i};
    e9       = {5'b0, n_e};
    ocup9    = 9'(OCUPACION);
    cap9     = 9'(CAPACIDAD);
    err_sig  = e9 > ocup9;
    acc_e    = err_sig ? ocup9 : e9;
    tras     = ocup9 - acc_e;
    libre    = cap9 - tras;
    rech_sig = i9 > libre;
    acc_i    = rech_sig ? libre : i9;
    ocup_sig = CNT_W'(tras + acc_i);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OCUPACION  <= '0;
      RECHAZO    <= 1'b0;
      ERR_EGRESO <= 1'b0;
    end else begin
      OCUPACION  <= ocup_sig;
      RECHAZO    <= rech_sig;
      ERR_EGRESO <= err_sig;
    end
  end

  assign LLENO = (OCUPACION == CNT_W'(CAPACIDAD));
  assign VACIO = (OCUPACION == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_blink <= '0;
      LED_LLENO <= 1'b0;
    end else if (!LLENO) begin
      cnt_blink <= '0;
      LED_LLENO <= 1'b0;
    end else if (cnt_blink == BLINK_W'(MEDIO_PERIODO - 1)) begin
      cnt_blink <= '0;
      LED_LLENO <= ~LED_LLENO;
    end else begin
      cnt_blink <= cnt_blink + BLINK_W'(1);
    end
  end

endmodule

// File: doc/control_estacionamiento_n.md
CONTROL_ESTACIONAMIENTO_N -- requirements
Module: control_estacionamiento_n

Interface
REQ-001 Parameter N_CARRILES, default 2, number of independent entry/exit lanes (1..8).
REQ-002 Parameter CAPACIDAD, default 7, maximum occupancy (1..255).
REQ-003 Parameter MEDIO_PERIODO, default 24000000, CLK cycles per blink half-period (2 s at 12 MHz).
REQ-004 Derived constant CNT_W = clog2(CAPACIDAD+1).
REQ-005 CLK  input  1  system clock, all logic rising-edge.
REQ-006 RST_N  input  1  reset; asynchronous assert, active-low.
REQ-007 SENS_A  input  N_CARRILES  per-lane sensor a, active-high, already debounced, asynchronous to CLK.
REQ-008 SENS_B  input  N_CARRILES  per-lane sensor b, same properties as SENS_A.
REQ-009 OCUPACION  output  CNT_W  current car count.
REQ-010 LLENO  output  1  high when OCUPACION == CAPACIDAD.
REQ-011 VACIO  output  1  high when OCUPACION == 0.
REQ-012 LED_LLENO  output  1  blinks while LLENO, else 0.
REQ-013 RECHAZO  output  1  one-cycle pulse: at least one entry dropped this cycle.
REQ-014 ERR_EGRESO  output  1  one-cycle pulse: at least one exit dropped this cycle.

Function
REQ-015 Each SENS_A/SENS_B bit SHALL pass a 2-flop synchronizer before use.
REQ-016 Each lane SHALL run an independent 7-state FSM on synchronized (a,b): IDLE, ENT1, ENT2, ENT3, SAL1, SAL2, SAL3.
REQ-017 IDLE: 10->ENT1, 01->SAL1, 00/11->IDLE.
REQ-018 ENT1: 10 stay, 11->ENT2, else IDLE; ENT2: 11 stay, 01->ENT3, 10->ENT1, 00->IDLE; ENT3: 01 stay, 11->ENT2, 00->IDLE with ingreso pulse, 10->IDLE.
REQ-019 SAL1/SAL2/SAL3 SHALL mirror ENT1/ENT2/ENT3 with a and b swapped; SAL3 on 00 emits egreso pulse.
REQ-020 Ingreso/egreso pulses SHALL be registered, one cycle wide, asserted the cycle after the FSM samples the completing 00.
REQ-021 OCUPACION SHALL update the cycle after the pulses; total latency raw sensor edge to OCUPACION = 4 CLK cycles.
REQ-022 Per cycle: I = count of ingreso pulses, E = count of egreso pulses across lanes; egresos applied first, then ingresos.
REQ-023 Accepted egresos = min(E, OCUPACION); if E exceeds it, ERR_EGRESO pulses same cycle as the OCUPACION update.
REQ-024 Accepted ingresos = min(I, CAPACIDAD - (OCUPACION - accepted egresos)); if I exceeds it, RECHAZO pulses same cycle.
REQ-025 OCUPACION SHALL never wrap; it stays within 0..CAPACIDAD under any pulse combination.
REQ-026 LLENO/VACIO SHALL be combinational from OCUPACION.
REQ-027 While LLENO, a blink counter SHALL count to MEDIO_PERIODO-1 then clear and toggle LED_LLENO; LED_LLENO first rises MEDIO_PERIODO cycles after LLENO rises.
REQ-028 When LLENO is low, blink counter and LED_LLENO SHALL be 0 the next cycle.

Reset
REQ-029 RST_N low SHALL immediately force synchronizers to 0, all FSMs to IDLE, OCUPACION 0, blink counter 0, LED_LLENO/RECHAZO/ERR_EGRESO 0.
REQ-030 Reset mid-sequence SHALL discard partial transits; after release lanes require a full sequence from IDLE.

Structure
REQ-031 Package estacionamiento_pkg SHALL hold the lane-state encoding and sensor-pattern constants.
REQ-032 Sub-module fsm_carril (one lane: FSM plus pulse register) SHALL be instantiated N_CARRILES times by generate.

Verification
REQ-033 Lane 0 drives 00,10,11,01,00 (each held 5 cycles) -> one ingreso, OCUPACION 0->1 exactly 4 cycles after final 00.
REQ-034 Lane 0 drives 10,11,10,00 -> no pulse, OCUPACION unchanged.
REQ-035 OCUPACION=6, CAPACIDAD=7, lanes 0 and 1 complete entries same cycle -> OCUPACION=7, LLENO=1, RECHAZO one pulse.
REQ-036 OCUPACION=0, lane 1 completes exit -> OCUPACION stays 0, ERR_EGRESO one pulse.
REQ-037 OCUPACION=3, lane 0 entry and lane 1 exit complete same cycle -> OCUPACION stays 3, no RECHAZO/ERR_EGRESO.
REQ-038 MEDIO_PERIODO=4, reach full -> LED_LLENO toggles every 4 cycles; one exit -> LED_LLENO 0 next cycle; RST_N pulse mid-ENT2 -> OCUPACION 0, no pulse.
